// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller:
// state encoding and the active-low hex-to-segment table.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  localparam int unsigned SEG_W = 7;

  // Active-low {g,f,e,d,c,b,a} patterns, indexed by hex value 0..F
  localparam logic [SEG_W-1:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg_c
);

  assign seg_c = SEG_LUT[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment display scanner with double-buffered digit data,
// inter-digit guard time and optional leading-zero blanking.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned DWELL    = 100000,
  parameter int unsigned GUARD    = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  blank_lz,
  output logic [N_DIGITS-1:0]   an,
  output logic [SEG_W-1:0]      seg,
  output logic                  dp,
  output logic                  pending,
  output logic                  frame
);

  localparam int unsigned DW      = 4 * N_DIGITS;
  localparam int unsigned IW      = $clog2(N_DIGITS);
  localparam int unsigned CNT_MAX = (DWELL > GUARD) ? DWELL : GUARD;
  localparam int unsigned CW      = $clog2(CNT_MAX);

  state_t                state;
  logic [IW-1:0]         idx;
  logic [CW-1:0]         cnt;
  logic [DW-1:0]         shadow_digits;
  logic [DW-1:0]         disp_digits;
  logic [N_DIGITS-1:0]   shadow_dp;
  logic [N_DIGITS-1:0]   disp_dp;

  logic                  dwell_done_c;
  logic                  guard_done_c;
  logic                  last_digit_c;
  logic                  wrap_c;
  logic                  boundary_c;
  logic [3:0]            nibble_c;
  logic                  dp_sel_c;
  logic                  zero_above_c;
  logic                  blank_c;
  logic [SEG_W-1:0]      dec_seg_c;

  assign dwell_done_c = (state == ST_DRIVE) && (cnt == CW'(DWELL - 1));
  assign guard_done_c = (state == ST_GUARD) && (cnt == CW'(GUARD - 1));
  assign last_digit_c = (idx == IW'(N_DIGITS - 1));
  assign wrap_c       = last_digit_c && ((GUARD == 0) ? dwell_done_c : guard_done_c);
  assign boundary_c   = enable && ((state == ST_IDLE) || wrap_c);

  // Scan sequencer: dwell on each digit, optional all-off guard, wrap to digit 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else if (!enable) begin
      state <= ST_IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_DRIVE;
          idx   <= '0;
          cnt   <= '0;
        end
        ST_DRIVE: begin
          if (dwell_done_c) begin
            cnt <= '0;
            if (GUARD == 0) begin
              idx <= last_digit_c ? '0 : idx + IW'(1);
            end else begin
              state <= ST_GUARD;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_GUARD: begin
          if (guard_done_c) begin
            state <= ST_DRIVE;
            cnt   <= '0;
            idx   <= last_digit_c ? '0 : idx + IW'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          idx   <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Double buffer: the display copy only moves on a frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_digits <= '0;
      shadow_dp     <= '0;
      disp_digits   <= '0;
      disp_dp       <= '0;
      pending       <= 1'b0;
      frame         <= 1'b0;
    end else begin
      frame <= boundary_c;
      if (load && boundary_c) begin
        shadow_digits <= digits_in;
        shadow_dp     <= dp_in;
        disp_digits   <= digits_in;
        disp_dp       <= dp_in;
        pending       <= 1'b0;
      end else if (load) begin
        shadow_digits <= digits_in;
        shadow_dp     <= dp_in;
        pending       <= 1'b1;
      end else if (boundary_c && pending) begin
        disp_digits <= shadow_digits;
        disp_dp     <= shadow_dp;
        pending     <= 1'b0;
      end
    end
  end

  // Selected digit and whether it sits inside the leading-zero run
  always_comb begin
    nibble_c     = 4'h0;
    dp_sel_c     = 1'b0;
    zero_above_c = 1'b1;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nibble_c = disp_digits[4*i +: 4];
        dp_sel_c = disp_dp[i];
      end
      if ((IW'(i) >= idx) && (disp_digits[4*i +: 4] != 4'h0)) begin
        zero_above_c = 1'b0;
      end
    end
  end

  assign blank_c = blank_lz && (idx != '0) && zero_above_c;

  seg7_decoder u_decoder (
    .nibble (nibble_c),
    .seg_c  (dec_seg_c)
  );

  // Output stage; dropping enable blanks on the very next edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= '1;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else if (!enable || (state != ST_DRIVE)) begin
      an  <= '1;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= ~(N_DIGITS'(1) << idx);
      seg <= blank_c ? SEG_OFF : dec_seg_c;
      dp  <= ~dp_sel_c;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with N_DIGITS=4, DWELL=4, GUARD=1
// (one frame = 20 cycles).
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        pending;
  logic        frame;

  int npass  = 0;
  int nfail  = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .N_DIGITS (4),
    .DWELL    (4),
    .GUARD    (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .load      (load),
    .digits_in (digits_in),
    .dp_in     (dp_in),
    .blank_lz  (blank_lz),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .pending   (pending),
    .frame     (frame)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks one whole frame starting at the negedge where frame was seen high.
  // s0..s3: expected seg per digit, dpl: expected active-low dp per digit.
  // load_k >= 0 pulses load before the edge that produces sample k.
  task automatic check_frame(input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3,
                             input logic [3:0] dpl, input int load_k,
                             input logic [15:0] ld, input logic [3:0] ldp);
    logic [6:0] sv [4];
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic       exp_pend;
    int         d;
    sv = '{s0, s1, s2, s3};
    for (int k = 0; k < 20; k++) begin
      if (k == load_k) begin
        load      = 1'b1;
        digits_in = ld;
        dp_in     = ldp;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
      d = k / 5;
      if ((k % 5) == 4) begin
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
        exp_dp  = 1'b1;
      end else begin
        exp_an  = ~(4'b0001 << d);
        exp_seg = sv[d];
        exp_dp  = dpl[d];
      end
      exp_pend = (load_k >= 0) && (load_k < 19) && (k >= load_k) && (k < 19);
      chk($sformatf("an[k=%0d]", k), 16'(an), 16'(exp_an));
      chk($sformatf("seg[k=%0d]", k), 16'(seg), 16'(exp_seg));
      chk($sformatf("dp[k=%0d]", k), 16'(dp), 16'(exp_dp));
      chk($sformatf("frame[k=%0d]", k), 16'(frame), 16'(k == 19));
      chk($sformatf("pending[k=%0d]", k), 16'(pending), 16'(exp_pend));
    end
    load = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b0;
    load      = 1'b0;
    digits_in = 16'h0000;
    dp_in     = 4'h0;
    blank_lz  = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_an", 16'(an), 16'hF);
    chk("rst_seg", 16'(seg), 16'h7F);
    chk("rst_dp", 16'(dp), 16'h1);
    chk("rst_pending", 16'(pending), 16'h0);
    chk("rst_frame", 16'(frame), 16'h0);

    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_an", 16'(an), 16'hF);

    // Load while idle: held in shadow until the scan starts
    load      = 1'b1;
    digits_in = 16'h1234;
    @(negedge clk);
    load = 1'b0;
    chk("idle_load_pending", 16'(pending), 16'h1);
    chk("idle_load_frame", 16'(frame), 16'h0);

    enable = 1'b1;
    @(negedge clk);
    chk("start_frame", 16'(frame), 16'h1);
    chk("start_pending", 16'(pending), 16'h0);
    chk("start_an", 16'(an), 16'hF);

    // 1234: digits 0..3 = 4,3,2,1
    check_frame(7'h19, 7'h30, 7'h24, 7'h79, 4'hF, -1, 16'h0, 4'h0);

    // Mid-frame load of 1111: old data for the rest of this frame
    blank_lz = 1'b1;
    check_frame(7'h19, 7'h30, 7'h24, 7'h79, 4'hF, 7, 16'h1111, 4'h0);

    // 1111 shown; load 0008 coincident with the closing boundary
    check_frame(7'h79, 7'h79, 7'h79, 7'h79, 4'hF, 19, 16'h0008, 4'h0);

    // 0008 with blanking; coincident load of 0000 with dp on digit 2
    check_frame(7'h00, 7'h7F, 7'h7F, 7'h7F, 4'hF, 19, 16'h0000, 4'b0100);

    // 0000 with blanking: only digit 0 lit, blanked digit 2 keeps its dp
    check_frame(7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b1011, 19, 16'h9AF0, 4'h0);

    // 9AF0: no leading zeros, zero in digit 0 still shown
    check_frame(7'h40, 7'h0E, 7'h08, 7'h10, 4'hF, -1, 16'h0, 4'h0);

    // Drop enable while digit 2 is driven
    repeat (12) @(negedge clk);
    chk("d2_an", 16'(an), 16'hB);
    chk("d2_seg", 16'(seg), 16'h08);
    enable = 1'b0;
    @(negedge clk);
    chk("off_an", 16'(an), 16'hF);
    chk("off_seg", 16'(seg), 16'h7F);
    chk("off_dp", 16'(dp), 16'h1);
    repeat (2) @(negedge clk);
    chk("off_hold_an", 16'(an), 16'hF);
    chk("off_frame", 16'(frame), 16'h0);

    enable = 1'b1;
    @(negedge clk);
    chk("reen_frame", 16'(frame), 16'h1);
    chk("reen_an", 16'(an), 16'hF);
    @(negedge clk);
    chk("reen_d0_an", 16'(an), 16'hE);
    chk("reen_d0_seg", 16'(seg), 16'h40);
    chk("reen_d0_frame", 16'(frame), 16'h0);

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_an", 16'(an), 16'hF);
    chk("arst_seg", 16'(seg), 16'h7F);
    chk("arst_dp", 16'(dp), 16'h1);
    chk("arst_pending", 16'(pending), 16'h0);
    chk("arst_frame", 16'(frame), 16'h0);

    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_frame", 16'(frame), 16'h1);
    chk("post_rst_an", 16'(an), 16'hF);
    @(negedge clk);
    chk("post_rst_d0_an", 16'(an), 16'hE);
    chk("post_rst_d0_seg", 16'(seg), 16'h40);
    repeat (5) @(negedge clk);
    chk("post_rst_d1_an", 16'(an), 16'hD);
    chk("post_rst_d1_seg", 16'(seg), 16'h7F);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter N_DIGITS, default 4: number of multiplexed digits, range 2..8.
REQ-002 Parameter DWELL, default 100000: clk cycles each digit is driven, minimum 2.
REQ-003 Parameter GUARD, default 1000: all-off cycles between digits, minimum 0.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port enable, input, 1: high runs the scan; low blanks the display.
REQ-007 Port load, input, 1: one-cycle strobe that captures digits_in and dp_in.
REQ-008 Port digits_in, input, 4*N_DIGITS: hex nibbles; digit i is [4i+3:4i]; digit 0 is least significant.
REQ-009 Port dp_in, input, N_DIGITS: decimal point per digit, active-high.
REQ-010 Port blank_lz, input, 1: enables leading-zero blanking.
REQ-011 Port an, output, N_DIGITS: anode enables, active-low, at most one low.
REQ-012 Port seg, output, 7: segments {g,f,e,d,c,b,a}, active-low.
REQ-013 Port dp, output, 1: decimal point, active-low.
REQ-014 Port pending, output, 1: high while captured data is not yet displayed.
REQ-015 Port frame, output, 1: one-cycle pulse at each frame boundary.

Function
REQ-016 States: IDLE (all anodes off), DRIVE (an[idx] low for DWELL cycles), GUARD (all anodes off for GUARD cycles).
REQ-017 Transitions: IDLE->DRIVE when enable=1; DRIVE->GUARD after DWELL cycles; GUARD->DRIVE after GUARD cycles with idx+1; with GUARD=0, DRIVE->DRIVE directly with idx+1.
REQ-018 idx wraps from N_DIGITS-1 to 0; the wrap and the IDLE->DRIVE entry are frame boundaries, and frame pulses in the cycle DRIVE starts at idx 0.
REQ-019 enable=0 in any state: IDLE on the next edge, idx=0, dwell counter cleared, an all ones; seg and dp are all ones in IDLE and GUARD.
REQ-020 load=1: digits_in and dp_in go into the shadow register next edge, and pending=1.
REQ-021 At a frame boundary with pending=1: shadow copies to the display register and pending=0.
REQ-022 Simultaneous load and frame boundary: digits_in and dp_in go directly to both registers; pending stays 0.
REQ-023 Multiple loads before a boundary: the last load wins.
REQ-024 The display register changes only at frame boundaries, so no frame mixes old and new data.
REQ-025 Decode covers hex 0-F with the standard patterns (active-low): 0=0x40, 1=0x79, 4=0x19, 8=0x00, F=0x0E.
REQ-026 Leading-zero blanking (blank_lz=1): zero digits from index N_DIGITS-1 downward, up to the first non-zero digit, drive seg=0x7F.
REQ-027 Digit 0 is never blanked; a digit's dp is still shown when its dp bit is set, even if the digit is blanked.
REQ-028 Outputs are registered; an, seg and dp change on the same edge, one cycle after the state/idx change.
REQ-029 Dwell counter width is $clog2(max(DWELL,GUARD)); no overflow is permitted.

Reset
REQ-030 rst_n=0 asynchronously forces: IDLE, idx=0, counters=0, shadow and display registers=0, pending=0, frame=0, an all ones, seg=0x7F, dp=1.
REQ-031 After rst_n rises, the first DRIVE needs enable high at a clk edge.
REQ-032 Reset asserted mid-frame aborts the frame without any glitch on an.

Structure
REQ-033 Package seg7_pkg holds the state encoding constants and the 16-entry hex-to-segment table.
REQ-034 Sub-module seg7_decoder (combinational nibble to seg) is instantiated once, on the selected digit.

Verification (N_DIGITS=4, DWELL=4, GUARD=1)
REQ-035 Reset, then enable=1 and load 0x1234 → each digit drives 4 cycles with 1 all-off cycle between.
REQ-036 Same scenario → an sequence 1110, 1111, 1101, 1111, 1011, 1111, 0111; seg on an=1110 is 0x19.
REQ-037 Load 0x0008 with blank_lz=1 → digits 3..1 show seg=0x7F and digit 0 shows 0x00.
REQ-038 Load 0x0000 with blank_lz=1 → only digit 0 lit, with seg=0x40.
REQ-039 Load 0x1111 in mid-frame → pending=1 until frame pulses; old data on all remaining digits of the current frame; new data from the next frame.
REQ-040 Load coincident with frame → new data shown in that same frame; pending never rises.
REQ-041 Drop enable during DRIVE of digit 2 → an all ones next cycle; re-enable → restart at digit 0 with a frame pulse.
REQ-042 Assert rst_n low between edges → outputs reach their reset values immediately, without a clk edge.
